key_schedule_iter: RTL and testbench

- Sequential, multi-size AES key expander; successor to the combinational 128-bit-only expander.
- Mode is selected at run time: 128, 192 or 256-bit key.
- Computes one 32-bit schedule word per cycle into an internal 60-word store, then streams 128-bit round keys to the cipher core over a valid/ready handshake, in ascending order (encrypt) or descending order (decrypt).
- A stored schedule can be replayed without recomputation.

---
 rtl/key_schedule_iter.sv | 240 ++++++++++++++++++++++++
 tb/tb_key_schedule_iter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle into a
// 60-word store, then round keys streamed over valid/ready in either order.
module key_schedule_iter #(
  parameter int MAX_WORDS = 60,
  parameter int RK_W      = 128
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      key_mode,
  input  logic [255:0]    key,
  input  logic            dir,
  input  logic            replay,
  output logic            busy,
  output logic            sched_valid,
  output logic            mode_err,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [RK_W-1:0] rk,
  output logic [3:0]      rk_idx,
  output logic            rk_last
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_STREAM = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  // Forward S-box, byte 0x00 in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[(11'd2047 - {b, 3'b000}) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'd1:    nk_of = 4'd6;
      2'd2:    nk_of = 4'd8;
      default: nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'd1:    nr_of = 4'd12;
      2'd2:    nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] total_of(input logic [1:0] m);
    case (m)
      2'd1:    total_of = 6'd52;
      2'd2:    total_of = 6'd60;
      default: total_of = 6'd44;
    endcase
  endfunction

  logic [31:0]     store_r [MAX_WORDS];
  state_t          state_r, state_nx_s;
  logic [1:0]      mode_r;
  logic            dir_r;
  logic [5:0]      i_r;
  logic [3:0]      kmod_r;
  logic [7:0]      rcon_r;
  logic [3:0]      r_r;
  logic [RK_W-1:0] rk_r;
  logic [3:0]      rk_idx_r;
  logic            rk_last_r, rk_valid_r, mode_err_r, busy_r, sched_valid_r;

  logic [3:0]      nk_s, nr_s;
  logic [5:0]      total_s, prev_idx_s, back_idx_s, rd_base_s;
  logic            idle_like_s, start_ok_s, start_bad_s, replay_ok_s;
  logic            expand_done_s, xfer_s, load_s, last_cond_s;
  logic [3:0]      r_next_s, kmod_next_s;
  logic [31:0]     prev_w_s, back_w_s, t_s, new_w_s;
  logic [RK_W-1:0] rd_key_s;

  // Control decode shared by the FSM and the datapath.
  always_comb begin
    nk_s          = nk_of(mode_r);
    nr_s          = nr_of(mode_r);
    total_s       = total_of(mode_r);
    idle_like_s   = (state_r == ST_IDLE) || (state_r == ST_READY);
    start_ok_s    = idle_like_s && start && (key_mode != 2'd3);
    start_bad_s   = idle_like_s && start && (key_mode == 2'd3);
    replay_ok_s   = (state_r == ST_READY) && replay && !start;
    expand_done_s = (state_r == ST_EXPAND) && (i_r == total_s - 6'd1);
    xfer_s        = rk_valid_r && rk_ready;
    // A new key is fetched when the output slot is empty or is being drained mid-stream.
    load_s        = (state_r == ST_STREAM) && (!rk_valid_r || (rk_ready && !rk_last_r));
    r_next_s      = dir_r ? (r_r - 4'd1) : (r_r + 4'd1);
    last_cond_s   = dir_r ? (r_r == 4'd0) : (r_r == nr_s);
    kmod_next_s   = (kmod_r == nk_s - 4'd1) ? 4'd0 : (kmod_r + 4'd1);
  end

  // Next-word computation for the expansion step.
  always_comb begin
    prev_idx_s = (i_r == 6'd0) ? 6'd0 : (i_r - 6'd1);
    back_idx_s = (i_r < {2'b00, nk_s}) ? 6'd0 : (i_r - {2'b00, nk_s});
    prev_w_s   = store_r[prev_idx_s];
    back_w_s   = store_r[back_idx_s];
    if (kmod_r == 4'd0) begin
      t_s = sub_word({prev_w_s[23:0], prev_w_s[31:24]}) ^ {rcon_r, 24'h000000};
    end else if ((nk_s == 4'd8) && (kmod_r == 4'd4)) begin
      t_s = sub_word(prev_w_s);
    end else begin
      t_s = prev_w_s;
    end
    new_w_s = back_w_s ^ t_s;
  end

  // Round-key read port; the pointer runs one past the end after the last fetch.
  always_comb begin
    rd_base_s = (r_r > nr_s) ? 6'd0 : {r_r, 2'b00};
    rd_key_s  = {store_r[rd_base_s], store_r[rd_base_s + 6'd1],
                 store_r[rd_base_s + 6'd2], store_r[rd_base_s + 6'd3]};
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_nx_s = ST_EXPAND;
        else            state_nx_s = ST_IDLE;
      end
      ST_EXPAND: begin
        if (expand_done_s) state_nx_s = ST_STREAM;
        else               state_nx_s = ST_EXPAND;
      end
      ST_STREAM: begin
        if (xfer_s && rk_last_r) state_nx_s = ST_READY;
        else                     state_nx_s = ST_STREAM;
      end
      ST_READY: begin
        if (start_ok_s)       state_nx_s = ST_EXPAND;
        else if (replay_ok_s) state_nx_s = ST_STREAM;
        else                  state_nx_s = ST_READY;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nx_s;
  end

  // Word store: key words on start, one derived word per expansion cycle.
  always_ff @(posedge clock) begin
    if (start_ok_s) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk_of(key_mode))) store_r[6'(j)] <= key[(255 - 32*j) -: 32];
      end
    end else if (state_r == ST_EXPAND) begin
      store_r[i_r] <= new_w_s;
    end
  end

  // Expansion counters, stream pointer and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_r        <= 2'd0;
      dir_r         <= 1'b0;
      i_r           <= 6'd0;
      kmod_r        <= 4'd0;
      rcon_r        <= 8'h00;
      r_r           <= 4'd0;
      rk_r          <= '0;
      rk_idx_r      <= 4'd0;
      rk_last_r     <= 1'b0;
      rk_valid_r    <= 1'b0;
      mode_err_r    <= 1'b0;
      busy_r        <= 1'b0;
      sched_valid_r <= 1'b0;
    end else begin
      mode_err_r    <= start_bad_s;
      busy_r        <= (state_nx_s == ST_EXPAND) || (state_nx_s == ST_STREAM);
      sched_valid_r <= (state_nx_s == ST_READY);
      if (start_ok_s) begin
        mode_r <= key_mode;
        dir_r  <= dir;
        i_r    <= {2'b00, nk_of(key_mode)};
        kmod_r <= 4'd0;
        rcon_r <= 8'h01;
      end else if (state_r == ST_EXPAND) begin
        i_r    <= i_r + 6'd1;
        kmod_r <= kmod_next_s;
        if (kmod_r == 4'd0) rcon_r <= xtime(rcon_r);
      end
      if (expand_done_s) begin
        r_r <= dir_r ? nr_s : 4'd0;
      end else if (replay_ok_s) begin
        dir_r <= dir;
        r_r   <= dir ? nr_s : 4'd0;
      end else if (load_s) begin
        r_r <= r_next_s;
      end
      if (load_s) begin
        rk_r       <= rd_key_s;
        rk_idx_r   <= r_r;
        rk_last_r  <= last_cond_s;
        rk_valid_r <= 1'b1;
      end else if (xfer_s && rk_last_r) begin
        rk_valid_r <= 1'b0;
      end
    end
  end

  assign busy        = busy_r;
  assign sched_valid = sched_valid_r;
  assign mode_err    = mode_err_r;
  assign rk_valid    = rk_valid_r;
  assign rk          = rk_r;
  assign rk_idx      = rk_idx_r;
  assign rk_last     = rk_last_r;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Scoreboard bench for key_schedule_iter: reference expansion built from a
// GF(2^8)-derived S-box, expected keys queued at launch and popped per transfer.
module tb_key_schedule_iter;

  localparam logic [255:0] K1 = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  logic         clock, reset_n, start, dir, replay, rk_ready;
  logic [1:0]   key_mode;
  logic [255:0] key;
  logic         busy, sched_valid, mode_err, rk_valid, rk_last;
  logic [127:0] rk;
  logic [3:0]   rk_idx;

  int           n_chk, n_fail, n_xfer;
  bit           bp_en;
  exp_t         exp_q[$];
  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  int           m_nr;
  logic [127:0] got_rk [16];

  key_schedule_iter dut (
    .clock(clock), .reset_n(reset_n), .start(start), .key_mode(key_mode),
    .key(key), .dir(dir), .replay(replay), .busy(busy),
    .sched_valid(sched_valid), .mode_err(mode_err), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // S-box from multiplicative inverse plus affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] a, s;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      a = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        a = rotl1(a);
        s ^= a;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub4(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] m, input logic [255:0] k);
    int nk  = (m == 2'd1) ? 6 : (m == 2'd2) ? 8 : 4;
    int tot;
    m_nr = nk + 6;
    tot  = 4 * (m_nr + 1);
    for (int i = 0; i < nk; i++) mw[i] = k[(255 - 32*i) -: 32];
    for (int i = nk; i < tot; i++) begin
      logic [31:0] t = mw[i-1];
      logic [7:0]  rc = 8'h01;
      if (i % nk == 0) begin
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub4(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic push_stream(input logic d);
    for (int n = 0; n <= m_nr; n++) begin
      exp_t e;
      int r = d ? (m_nr - n) : n;
      e.rk   = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      e.idx  = 4'(r);
      e.last = (n == m_nr);
      exp_q.push_back(e);
    end
    n_xfer = 0;
    for (int i = 0; i < 16; i++) got_rk[i] = '0;
  endtask

  // Backpressure source; fully ready unless bp_en is set.
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      rk_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: every presented key must match the queue head, stalled or not.
  always @(negedge clock) begin
    if (reset_n && rk_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rk_extra", 128'(rk_valid), 128'd0);
      end else begin
        check_eq("rk_val", rk, exp_q[0].rk);
        check_eq("rk_idx_last", {123'd0, rk_idx, rk_last}, {123'd0, exp_q[0].idx, exp_q[0].last});
        if (rk_ready) begin
          got_rk[rk_idx] = rk;
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  task automatic run_start(input logic [1:0] m, input logic [255:0] k, input logic d);
    model_expand(m, k);
    push_stream(d);
    @(posedge clock); #1;
    start = 1'b1; key_mode = m; key = k; dir = d;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("start_busy", 128'(busy), 128'd1);
    check_eq("start_sv", 128'(sched_valid), 128'd0);
  endtask

  task automatic replay_go(input logic d);
    push_stream(d);
    @(posedge clock); #1;
    replay = 1'b1; dir = d;
    @(posedge clock); #1;
    replay = 1'b0;
    check_eq("replay_busy", 128'(busy), 128'd1);
  endtask

  task automatic wait_stream(input string tag, input int cyc0, input int lat, input int nx);
    int cyc = cyc0;
    while (!rk_valid && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
    check_eq({tag, "_lat"}, 128'(cyc), 128'(lat));
    cyc = 0;
    while (!sched_valid && cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check_eq({tag, "_done"}, 128'(sched_valid), 128'd1);
    check_eq({tag, "_qleft"}, 128'(exp_q.size()), 128'd0);
    check_eq({tag, "_nxfer"}, 128'(n_xfer), 128'(nx));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 128'(busy), 128'd0);
    check_eq({tag, "_sv"}, 128'(sched_valid), 128'd0);
    check_eq({tag, "_merr"}, 128'(mode_err), 128'd0);
    check_eq({tag, "_rkv"}, 128'(rk_valid), 128'd0);
    check_eq({tag, "_rkl"}, 128'(rk_last), 128'd0);
    check_eq({tag, "_rkidx"}, 128'(rk_idx), 128'd0);
    check_eq({tag, "_rk"}, rk, 128'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_xfer = 0; bp_en = 1'b0;
    reset_n = 1'b0; start = 1'b0; replay = 1'b0; dir = 1'b0;
    key_mode = 2'd0; key = '0;
    build_sbox();
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset");
    reset_n = 1'b1;

    // FIPS-197 A.1, ascending, always ready
    run_start(2'd0, K1, 1'b0);
    wait_stream("a1", 0, 41, 11);
    check_eq("a1_r0", got_rk[0], K1[255:128]);
    check_eq("a1_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // A.1 again with random backpressure, then reversed replay
    bp_en = 1'b1;
    run_start(2'd0, K1, 1'b0);
    wait_stream("a1_bp", 0, 41, 11);
    bp_en = 1'b0;
    replay_go(1'b1);
    wait_stream("a1_rev", 0, 1, 11);
    check_eq("a1_rev_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Illegal mode while a schedule is held
    @(posedge clock); #1;
    start = 1'b1; key_mode = 2'd3; key = K3; dir = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; key_mode = 2'd0;
    check_eq("merr_pulse", 128'(mode_err), 128'd1);
    check_eq("merr_sv", 128'(sched_valid), 128'd1);
    check_eq("merr_busy", 128'(busy), 128'd0);
    @(posedge clock); #1;
    check_eq("merr_clear", 128'(mode_err), 128'd0);
    check_eq("merr_sv2", 128'(sched_valid), 128'd1);
    replay_go(1'b0);
    wait_stream("a1_replay", 0, 1, 11);
    check_eq("replay_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // FIPS-197 A.2, descending
    run_start(2'd1, K2, 1'b1);
    wait_stream("a2", 0, 47, 13);
    check_eq("a2_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    check_eq("a2_r0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);

    // FIPS-197 A.3 with a start pulse during expansion that must be ignored
    run_start(2'd2, K3, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    start = 1'b1; key_mode = 2'd0; key = K1; dir = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_stream("a3", 6, 53, 15);
    check_eq("a3_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset in the middle of an A.1 expansion, then a clean rerun
    run_start(2'd0, K1, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    start = 1'b1; key_mode = 2'd2; key = K3;
    @(posedge clock); #1;
    start = 1'b0; key_mode = 2'd0;
    check_eq("ign_busy", 128'(busy), 128'd1);
    repeat (10) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle("midrst");
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    run_start(2'd0, K1, 1'b0);
    wait_stream("a1_rerun", 0, 41, 11);
    check_eq("rerun_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
